// File: rtl/lk_route_share_ctrl_pkg.sv
// Shared helpers for the look-ahead routing files: log2 sizing and packed-port slot indexing.
package lk_route_share_ctrl_pkg;

  // Minimum 1 so a single-port build still gets a legal index width.
  function automatic int lk_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int slot_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/lk_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins, ptr moves past the winner on adv.
// Combinational grant, pointer updates at the clock edge; non-power-of-two P wraps explicitly.
module lk_rr_arbiter
  import lk_route_share_ctrl_pkg::*;
#(
  parameter int P    = 5,
  parameter int PTRW = lk_log2(P)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [P-1:0]    req,
  input  logic            adv,
  output logic [P-1:0]    gnt,
  output logic [PTRW-1:0] gnt_idx
);

  localparam int IW = PTRW + 1;
  localparam logic [IW-1:0] PW = IW'(P);
  localparam logic [PTRW-1:0] LAST = PTRW'(P - 1);

  logic [PTRW-1:0] ptr;
  logic [IW-1:0]   idx;

  // Scan from the farthest slot back to ptr so the nearest requester is assigned last and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = P - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= PW) idx = idx - PW;
      if (req[idx[PTRW-1:0]]) begin
        gnt                  = '0;
        gnt[idx[PTRW-1:0]]   = 1'b1;
        gnt_idx              = idx[PTRW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + PTRW'(1);
    end
  end

endmodule

// File: rtl/lk_route_share_ctrl.sv
// Time-shares one look-ahead routing unit among P ports: RR grant, issue register, ack 2 cycles later.
// No stall path: one grant per cycle, a port stays ineligible until after its ack. LKROUTE_WAIT_MON_EN adds wait_max.
module lk_route_share_ctrl
  import lk_route_share_ctrl_pkg::*;
#(
  parameter int P     = 5,
  parameter int EAw   = 3,
  parameter int DSTPw = 4,
  parameter int WAITw = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [P-1:0]       req,
  input  logic [P*EAw-1:0]   req_dest_e_addr,
  input  logic [P*DSTPw-1:0] req_destport,
  output logic [P-1:0]       ack,
  output logic [DSTPw-1:0]   resp_lkdestport,
  output logic               rt_valid,
  output logic [EAw-1:0]     rt_dest_e_addr,
  output logic [DSTPw-1:0]   rt_destport,
  input  logic [DSTPw-1:0]   rt_lkdestport,
  output logic [WAITw-1:0]   wait_max
);

  localparam int PTRW = lk_log2(P);

  logic [P-1:0]     iss_oh;
  logic [P-1:0]     elig;
  logic [P-1:0]     gnt;
  logic [PTRW-1:0]  gnt_idx;
  logic             grant;
  logic [EAw-1:0]   sel_ea;
  logic [DSTPw-1:0] sel_dp;

  // A port is locked out while its operands sit in the issue stage and during its ack cycle.
  assign elig  = req & ~(iss_oh | ack);
  assign grant = |gnt;

  lk_rr_arbiter #(.P(P), .PTRW(PTRW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .adv     (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_ea = '0;
    sel_dp = '0;
    for (int i = 0; i < P; i++) begin
      if (gnt_idx == PTRW'(i)) begin
        sel_ea = req_dest_e_addr[slot_lo(i, EAw) +: EAw];
        sel_dp = req_destport[slot_lo(i, DSTPw) +: DSTPw];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt_valid       <= 1'b0;
      iss_oh         <= '0;
      rt_dest_e_addr <= '0;
      rt_destport    <= '0;
    end else begin
      rt_valid <= grant;
      iss_oh   <= gnt;
      if (grant) begin
        rt_dest_e_addr <= sel_ea;
        rt_destport    <= sel_dp;
      end
    end
  end

  // The shared unit is combinational, so its answer is captured in the issue cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack             <= '0;
      resp_lkdestport <= '0;
    end else begin
      ack <= iss_oh;
      if (rt_valid) resp_lkdestport <= rt_lkdestport;
    end
  end

`ifdef LKROUTE_WAIT_MON_EN
  logic [WAITw-1:0] wait_cnt [P];
  logic [WAITw-1:0] cnt_max;

  always_comb begin
    cnt_max = wait_max;
    for (int i = 0; i < P; i++) begin
      if (wait_cnt[i] > cnt_max) cnt_max = wait_cnt[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < P; i++) wait_cnt[i] <= '0;
      wait_max <= '0;
    end else begin
      for (int i = 0; i < P; i++) begin
        if (gnt[i]) wait_cnt[i] <= '0;
        else if (req[i] && (wait_cnt[i] != '1)) wait_cnt[i] <= wait_cnt[i] + WAITw'(1);
      end
      wait_max <= cnt_max;
    end
  end
`else
  assign wait_max = '0;
`endif

endmodule

// File: tb/tb_lk_route_share_ctrl.sv
// Bench for lk_route_share_ctrl: directed phases then random traffic, checked by a queue scoreboard.
module tb_lk_route_share_ctrl;
  localparam int P = 5, EAw = 3, DSTPw = 4, WAITw = 8;
  localparam int WSAT = (1 << WAITw) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [P-1:0]       req;
  logic [P*EAw-1:0]   req_ea;
  logic [P*DSTPw-1:0] req_dp;
  logic [P-1:0]       ack;
  logic [DSTPw-1:0]   resp, rt_dp, rt_lk;
  logic               rt_valid;
  logic [EAw-1:0]     rt_ea;
  logic [WAITw-1:0]   wait_max;

  logic [2:0]   req3, ack3;
  logic [8:0]   ea3;
  logic [11:0]  dp3;
  logic [3:0]   resp3, rtdp3, rtlk3;
  logic         vld3;
  logic [2:0]   rtea3;
  logic [7:0]   wm3;

  always #5 clk = ~clk;

  // Stand-in for the shared routing unit.
  function automatic logic [DSTPw-1:0] stub(input logic [EAw-1:0] ea, input logic [DSTPw-1:0] dp);
    return DSTPw'((int'(ea) + int'(dp)) * 2);
  endfunction

  assign rt_lk = stub(rt_ea, rt_dp);
  assign rtlk3 = stub(rtea3, rtdp3);

  lk_route_share_ctrl #(.P(P), .EAw(EAw), .DSTPw(DSTPw), .WAITw(WAITw)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dest_e_addr(req_ea), .req_destport(req_dp),
    .ack(ack), .resp_lkdestport(resp), .rt_valid(rt_valid), .rt_dest_e_addr(rt_ea),
    .rt_destport(rt_dp), .rt_lkdestport(rt_lk), .wait_max(wait_max)
  );

  lk_route_share_ctrl #(.P(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_dest_e_addr(ea3), .req_destport(dp3),
    .ack(ack3), .resp_lkdestport(resp3), .rt_valid(vld3), .rt_dest_e_addr(rtea3),
    .rt_destport(rtdp3), .rt_lkdestport(rtlk3), .wait_max(wm3)
  );

  typedef struct {
    int due;
    int port;
    logic [EAw-1:0]   ea;
    logic [DSTPw-1:0] dp;
    logic [DSTPw-1:0] lk;
  } exp_t;

  exp_t iss_q[$];
  exp_t ack_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = -1;

  // Reference model state: requester intent plus grant history.
  int ptr_m;
  int last_g[P], done_c[P], renew[P], wcnt[P];
  int wmax;
  bit pend[P];
  bit in_rst;
  logic [EAw-1:0]   ea_m[P];
  logic [DSTPw-1:0] dp_m[P];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic raise(input int i, input int rn);
    pend[i]  = 1'b1;
    renew[i] = rn;
    ea_m[i]  = EAw'($urandom);
    dp_m[i]  = DSTPw'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < P; i++) begin
      req[i]                   = pend[i];
      req_ea[i*EAw +: EAw]     = ea_m[i];
      req_dp[i*DSTPw +: DSTPw] = dp_m[i];
    end
  endtask

  task automatic flush_model();
    iss_q.delete();
    ack_q.delete();
    ptr_m = 0;
    wmax  = 0;
    for (int i = 0; i < P; i++) begin
      last_g[i] = -100;
      done_c[i] = -100;
      wcnt[i]   = 0;
    end
  endtask

  // One arbitration cycle: port eligible if requesting and its last grant is 3+ cycles old.
  task automatic model_step(input int c);
    int w;
    exp_t e;
    w = -1;
    for (int k = 0; k < P; k++) begin
      int i;
      i = (ptr_m + k) % P;
      if (w < 0 && pend[i] && (c - last_g[i]) >= 3) w = i;
    end
    if (w >= 0) begin
      e.due = c + 1; e.port = w; e.ea = ea_m[w]; e.dp = dp_m[w]; e.lk = stub(ea_m[w], dp_m[w]);
      iss_q.push_back(e);
      e.due = c + 2;
      ack_q.push_back(e);
      last_g[w] = c;
      done_c[w] = c + 2;
      ptr_m     = (w + 1) % P;
    end
    for (int i = 0; i < P; i++) begin
      if (i == w) wcnt[i] = 0;
      else if (pend[i] && wcnt[i] < WSAT) wcnt[i]++;
      if (wcnt[i] > wmax) wmax = wcnt[i];
    end
  endtask

  task automatic random_traffic(input int c);
    for (int i = 0; i < P; i++) begin
      if (pend[i] && done_c[i] >= c && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      else if (!pend[i] && done_c[i] < c && $urandom_range(0, 3) == 0) raise(i, $urandom_range(0, 2));
    end
  endtask

  task automatic directed_checks(input int c);
    case (c)
      2, 3, 4, 5, 6: chk("allreq_ack_order", ack, 64'(1) << (c - 2));
      7:  chk("allreq_no_repeat", ack, 0);
`ifdef LKROUTE_WAIT_MON_EN
      8:  chk("wait_max_allreq", wait_max, 4);
`endif
      11: begin
        chk("single_rt_valid", rt_valid, 1);
        chk("single_rt_ea", rt_ea, 3);
        chk("single_rt_dp", rt_dp, 2);
      end
      12: begin
        chk("single_ack", ack, 5'b00100);
        chk("single_resp", resp, 4'b1010);
      end
      17: chk("rereq_first_ack", ack, 5'b00010);
      20: chk("waiter_before_rereq", ack, 5'b01000);
      22: chk("rereq_second_ack", ack, 5'b00010);
      36: chk("post_reset_ack", ack, 5'b00001);
      default: ;
    endcase
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents an issue or an ack.
  initial begin
    exp_t e;
    logic [P-1:0] oh;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (rt_valid) begin
          if (iss_q.size() == 0) chk("issue_unexpected", rt_valid, 0);
          else begin
            e = iss_q.pop_front();
            chk("issue_cycle", cyc, e.due);
            chk("issue_ea", rt_ea, e.ea);
            chk("issue_dp", rt_dp, e.dp);
          end
        end else if (iss_q.size() > 0 && iss_q[0].due <= cyc) begin
          void'(iss_q.pop_front());
          chk("issue_missing", rt_valid, 1);
        end
        if (ack != '0) begin
          if (ack_q.size() == 0) chk("ack_unexpected", ack, 0);
          else begin
            e = ack_q.pop_front();
            oh = '0; oh[e.port] = 1'b1;
            chk("ack_cycle", cyc, e.due);
            chk("ack_port", ack, oh);
            chk("ack_resp", resp, e.lk);
          end
        end else if (ack_q.size() > 0 && ack_q[0].due <= cyc) begin
          e = ack_q.pop_front();
          oh = '0; oh[e.port] = 1'b1;
          chk("ack_missing", ack, oh);
        end
      end
    end
  end

  // P=3 instance: port 1 alone moves ptr to 2, then req=011 must wrap to port 0 before port 1.
  initial begin
    req3 = '0; ea3 = '0; dp3 = '0;
    wait (reset === 1'b1);
    req3 = 3'b010; ea3[3 +: 3] = 3'd1; dp3[4 +: 4] = 4'd1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin req3 = 3'b011; ea3[0 +: 3] = 3'd5; dp3[0 +: 4] = 4'd6; end
      if (k == 6) req3 = 3'b010;
      if (k == 7) req3 = 3'b000;
      @(negedge clk);
      case (k)
        2: chk("p3_first_ack", ack3, 3'b010);
        4: chk("p3_wrap_issue_ea", rtea3, 5);
        5: chk("p3_wrap_ack0", ack3, 3'b001);
        6: chk("p3_wrap_ack1", ack3, 3'b010);
        7: chk("p3_idle", ack3, 0);
        default: ;
      endcase
      @(posedge clk); #1;
    end
  end

  initial begin
    reset = 1'b0; req = '0; req_ea = '0; req_dp = '0; in_rst = 1'b1;
    flush_model();
    for (int i = 0; i < P; i++) begin pend[i] = 1'b0; renew[i] = 0; ea_m[i] = '0; dp_m[i] = '0; end
    #2;
    chk("rst_ack", ack, 0);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_rt_ea", rt_ea, 0);
    chk("rst_rt_dp", rt_dp, 0);
    chk("rst_resp", resp, 0);
    chk("rst_wait_max", wait_max, 0);
    @(posedge clk); #1;
    for (int c = 0; c <= 1440; c++) begin
      cyc = c;
      if (c == 0 || c == 34) begin reset = 1'b1; in_rst = 1'b0; end
      for (int i = 0; i < P; i++) begin
        if (done_c[i] == c - 1) begin
          if (renew[i] > 0) raise(i, renew[i] - 1);
          else pend[i] = 1'b0;
        end
      end
      case (c)
        0, 30: for (int i = 0; i < P; i++) raise(i, 0);
        10: begin raise(2, 0); ea_m[2] = 3'd3; dp_m[2] = 4'd2; end
        15: raise(1, 1);
        17: begin raise(2, 0); raise(3, 0); raise(4, 0); end
        default: ;
      endcase
      if (c >= 45 && c < 1400) random_traffic(c);
      drive();
      @(negedge clk);
      if (!in_rst) model_step(c);
      directed_checks(c);
      if (c == 31) begin
        chk("pre_reset_valid", rt_valid, 1);
        #2 reset = 1'b0;
        in_rst = 1'b1;
        #1;
        chk("async_rst_valid", rt_valid, 0);
        chk("async_rst_ack", ack, 0);
        chk("async_rst_resp", resp, 0);
        flush_model();
      end
      @(posedge clk); #1;
    end
    chk("drain_issue_q", iss_q.size(), 0);
    chk("drain_ack_q", ack_q.size(), 0);
`ifdef LKROUTE_WAIT_MON_EN
    chk("wait_max_final", wait_max, wmax);
`else
    chk("wait_max_tied", wait_max, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
